// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 single-bit mux.
// Eight requesters compete and one at a time gets the mux select and a one-hot grant.
// A grant lasts at most MAX_HOLD cycles. When that limit forces a release,
// preempt pulses for one cycle.
// Each release is followed by a TURN cycle and then the IDLE cycle in which the next
// arbitration happens, so a new winner is always picked from a settled pointer.
module mux_sel_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    // Count value on the last cycle a grant may be held.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             timeout;
    logic             dropped;
    logic             release_now;

    // Rotating priority search: first requester at or after the pointer, wrapping mod 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Release causes while a grant is active; timeout alone is what makes a preemption.
    always_comb begin
        timeout     = (cnt_q == HOLD_LAST);
        dropped     = ~req[sel_q];
        release_now = done | dropped | timeout;
    end

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        preempt_d = preempt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    sel_d   = win_idx;
                    grant_d = 8'b1 << win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d   = TURN;
                    grant_d   = 8'h00;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + 3'd1;
                    preempt_d = timeout & ~done & ~dropped;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TURN: begin
                state_d   = IDLE;
                preempt_d = 1'b0;
                cnt_d     = '0;
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 8'h00;
                valid_d   = 1'b0;
                preempt_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // All arbiter state and outputs are registered here, with a synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            sel_q     <= 3'd0;
            grant_q   <= 8'h00;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed self-checking bench for mux_sel_rr_arbiter, built with MAX_HOLD=4.
module tb_mux_sel_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       preempt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] e_grant;
        logic [2:0] e_sel;
        logic       e_valid;
        logic       e_preempt;
    } vec_t;

    vec_t vecs[13];

    mux_sel_rr_arbiter #(
        .MAX_HOLD(4),
        .CNT_W   (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .sel    (sel),
        .grant  (grant),
        .valid  (valid),
        .preempt(preempt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic d);
        reset = r;
        req   = rq;
        done  = d;
    endtask

    // Advance one clock, sample 1 ns after the edge, and check the output invariants.
    task automatic tick();
        logic inv;
        @(posedge clk);
        #1;
        inv = (valid == (|grant)) && $onehot0(grant) && (!valid || grant[sel]);
        checkOutput("invariant", {7'd0, inv}, 8'd1);
    endtask

    // Wait up to a bounded number of cycles for a grant, then check which requester won.
    task automatic waitGrant(input string name, input logic [2:0] exp_sel);
        int n;
        n = 0;
        while (!valid && n < 4) begin
            tick();
            n++;
        end
        checkOutput({name, "_valid"}, {7'd0, valid}, 8'd1);
        checkOutput({name, "_sel"}, {5'd0, sel}, {5'd0, exp_sel});
        checkOutput({name, "_grant"}, grant, 8'b1 << exp_sel);
    endtask

    initial begin
        applyStimulus(1'b1, 8'h00, 1'b0);

        // Reset with every requester active, then a single request released by done.
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        // Pointer is now 6, so 6 beats 0.
        vecs[5]  = '{1'b0, 8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h41, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0};
        // Grant 4, reset mid-grant, then the pointer is back at 0 so 0 beats 4.
        vecs[8]  = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h11, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        // Requester 0 drops its request: release without preemption.
        vecs[11] = '{1'b0, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].done);
            tick();
            checkOutput($sformatf("vec%0d_grant", i), grant, vecs[i].e_grant);
            checkOutput($sformatf("vec%0d_sel", i), {5'd0, sel}, {5'd0, vecs[i].e_sel});
            checkOutput($sformatf("vec%0d_valid", i), {7'd0, valid}, {7'd0, vecs[i].e_valid});
            checkOutput($sformatf("vec%0d_preempt", i), {7'd0, preempt}, {7'd0, vecs[i].e_preempt});
        end

        // Timeout: the pointer is 1 and req=0C, so 2 holds for exactly 4 cycles and is preempted.
        applyStimulus(1'b0, 8'h0C, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checkOutput($sformatf("hold%0d_grant", c), grant, 8'h04);
            checkOutput($sformatf("hold%0d_preempt", c), {7'd0, preempt}, 8'd0);
        end
        tick();
        checkOutput("to_rel_grant", grant, 8'h00);
        checkOutput("to_rel_preempt", {7'd0, preempt}, 8'd1);
        tick();
        checkOutput("to_turn_grant", grant, 8'h00);
        checkOutput("to_turn_preempt", {7'd0, preempt}, 8'd0);
        waitGrant("after_to", 3'd3);

        // Done arrives on the timeout cycle: this is a normal release without preemption.
        tick();
        tick();
        tick();
        checkOutput("both_hold_grant", grant, 8'h08);
        done = 1'b1;
        tick();
        checkOutput("both_rel_grant", grant, 8'h00);
        checkOutput("both_rel_preempt", {7'd0, preempt}, 8'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();

        // Full rotation from a fresh reset with done pulsed on each grant's first cycle.
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        for (int g = 0; g < 9; g++) begin
            waitGrant($sformatf("rr%0d", g), 3'(g % 8));
            done = 1'b1;
            tick();
            checkOutput($sformatf("rr%0d_gap", g), grant, 8'h00);
            done = 1'b0;
        end

        // Wrap: after 6 is granted, req=81 must give 7 first and then 0.
        applyStimulus(1'b0, 8'h40, 1'b0);
        waitGrant("pre6", 3'd6);
        applyStimulus(1'b0, 8'h81, 1'b1);
        tick();
        done = 1'b0;
        waitGrant("wrap7", 3'd7);
        done = 1'b1;
        tick();
        done = 1'b0;
        waitGrant("wrap0", 3'd0);
        done = 1'b1;
        tick();
        checkOutput("wrap_end_grant", grant, 8'h00);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
